// File: rtl/pll_reset_sequencer_if.sv
// Control/status bundle between the PLL reset sequencer and the system.
// master: system side (drives locked, soft_reset); slave: sequencer side.
interface pll_reset_sequencer_if;
    logic       locked;
    logic       soft_reset;
    logic       pll_rst;
    logic       sys_reset;
    logic       sdram_init_ok;
    logic [7:0] lock_lost_cnt;
    logic [7:0] timeout_cnt;
    logic [2:0] state;

    modport master (
        output locked, soft_reset,
        input  pll_rst, sys_reset, sdram_init_ok,
        input  lock_lost_cnt, timeout_cnt, state
    );

    modport slave (
        input  locked, soft_reset,
        output pll_rst, sys_reset, sdram_init_ok,
        output lock_lost_cnt, timeout_cnt, state
    );
endinterface

// File: rtl/pll_reset_sequencer.sv
// Sequences PLL reset, lock qualification and SDRAM power-up wait on refclk.
// Ports: refclk, rst (async, active high), bus (slave: locked/soft_reset in,
// pll_rst/sys_reset/sdram_init_ok/lock_lost_cnt/timeout_cnt/state out).
module pll_reset_sequencer #(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int SDRAM_WAIT_CYCLES   = 10000,
    parameter int CNT_W               = 16
) (
    input  logic                  refclk,
    input  logic                  rst,
    pll_reset_sequencer_if.slave  bus
);

    localparam logic [2:0] S_PLLRST    = 3'd0;
    localparam logic [2:0] S_WAITLOCK  = 3'd1;
    localparam logic [2:0] S_STABLE    = 3'd2;
    localparam logic [2:0] S_SDRAMWAIT = 3'd3;
    localparam logic [2:0] S_RUN       = 3'd4;

    localparam logic [CNT_W-1:0] LD_PLLRST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_WAIT   = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_STABLE = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_SDRAM  = CNT_W'(SDRAM_WAIT_CYCLES - 1);

    logic             locked_m;
    logic             locked_s;
    logic [2:0]       state_q;
    logic [2:0]       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] load_val;
    logic             enter;
    logic             inc_lost;
    logic             inc_to;
    logic             pll_rst_q;
    logic             sys_reset_q;
    logic             sdram_ok_q;
    logic [7:0]       lost_q;
    logic [7:0]       to_q;

    // Two-flop synchronizer for the asynchronous PLL lock flag
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            locked_m <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            locked_m <= bus.locked;
            locked_s <= locked_m;
        end
    end

    always_comb begin
        state_d  = state_q;
        inc_lost = 1'b0;
        inc_to   = 1'b0;
        case (state_q)
            S_PLLRST: begin
                if (cnt_q == '0)
                    state_d = S_WAITLOCK;
            end
            S_WAITLOCK: begin
                if (locked_s) begin
                    state_d = S_STABLE;
                end else if (cnt_q == '0) begin
                    state_d = S_PLLRST;
                    inc_to  = 1'b1;
                end
            end
            S_STABLE: begin
                // A drop here only restarts the lock wait; not a loss event
                if (!locked_s)
                    state_d = S_WAITLOCK;
                else if (cnt_q == '0)
                    state_d = S_SDRAMWAIT;
            end
            S_SDRAMWAIT: begin
                if (!locked_s) begin
                    state_d  = S_PLLRST;
                    inc_lost = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!locked_s) begin
                    state_d  = S_PLLRST;
                    inc_lost = 1'b1;
                end
            end
            default: state_d = S_PLLRST;
        endcase

        // Soft reset overrides everything but still lets a
        // coincident lock loss be counted; a timeout is not counted
        if (bus.soft_reset) begin
            state_d = S_PLLRST;
            inc_to  = 1'b0;
        end
    end

    // Counter reloads on every state entry, including a
    // soft-reset re-entry of S_PLLRST
    assign enter = (state_d != state_q) || bus.soft_reset;

    always_comb begin
        load_val = '0;
        case (state_d)
            S_PLLRST:    load_val = LD_PLLRST;
            S_WAITLOCK:  load_val = LD_WAIT;
            S_STABLE:    load_val = LD_STABLE;
            S_SDRAMWAIT: load_val = LD_SDRAM;
            default:     load_val = '0;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (enter)
            cnt_d = load_val;
        else if (cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q     <= S_PLLRST;
            cnt_q       <= LD_PLLRST;
            pll_rst_q   <= 1'b1;
            sys_reset_q <= 1'b1;
            sdram_ok_q  <= 1'b0;
            lost_q      <= 8'd0;
            to_q        <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            // Outputs decoded from the next state so they change
            // on the same edge as state
            pll_rst_q   <= (state_d == S_PLLRST);
            sys_reset_q <= (state_d == S_PLLRST) ||
                           (state_d == S_WAITLOCK) ||
                           (state_d == S_STABLE);
            sdram_ok_q  <= (state_d == S_RUN);
            if (inc_lost && (lost_q != 8'hFF))
                lost_q <= lost_q + 8'd1;
            if (inc_to && (to_q != 8'hFF))
                to_q <= to_q + 8'd1;
        end
    end

    assign bus.state         = state_q;
    assign bus.pll_rst       = pll_rst_q;
    assign bus.sys_reset     = sys_reset_q;
    assign bus.sdram_init_ok = sdram_ok_q;
    assign bus.lock_lost_cnt = lost_q;
    assign bus.timeout_cnt   = to_q;

endmodule
